// File: rtl/fifo_pkg.sv
// fifo_pkg: width helpers shared by the synchronous FIFO family
package fifo_pkg;
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_sync_fwft_if.sv
// fifo_sync_fwft_if: push/pop handshake, thresholds and status of fifo_sync_fwft
interface fifo_sync_fwft_if #(
    parameter int DWIDTH = 24,
    parameter int DEPTH  = 256
);
    import fifo_pkg::*;
    localparam int CW = lvl_w(DEPTH);
    logic              flush;
    logic              push;
    logic [DWIDTH-1:0] data_in;
    logic              full;
    logic              alFull;
    logic              pop;
    logic              vld;
    logic [DWIDTH-1:0] data_out;
    logic              alEmpty;
    logic [CW-1:0]     level;
    logic [CW-1:0]     afull_thresh;
    logic [CW-1:0]     aempty_thresh;
    logic              err_clr;
    logic              overflow;
    logic              underflow;
    modport master (
        output flush, push, data_in, pop, afull_thresh, aempty_thresh, err_clr,
        input  full, alFull, vld, data_out, alEmpty, level, overflow, underflow
    );
    modport slave (
        input  flush, push, data_in, pop, afull_thresh, aempty_thresh, err_clr,
        output full, alFull, vld, data_out, alEmpty, level, overflow, underflow
    );
endinterface

// File: rtl/fifo_prefetch2.sv
// fifo_prefetch2: two-entry first-word-fall-through output buffer fed by the RAM read port
module fifo_prefetch2 #(
    parameter int DWIDTH = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ld,
    input  logic [DWIDTH-1:0] din,
    input  logic              pop,
    output logic              vld,
    output logic [DWIDTH-1:0] data_out,
    output logic [1:0]        occ
);
    logic [DWIDTH-1:0] e0, e1, s0, s1;
    // a word arriving on din is already the head in its landing cycle, which keeps push-to-vld at two cycles
    always_comb begin
        vld      = occ != 2'd0 || ld;
        data_out = occ != 2'd0 ? e0 : ld ? din : '0;
        s0       = occ != 2'd0 ? e0 : din;
        s1       = occ[1] ? e1 : din;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) occ <= 2'd0;
        else occ <= occ + {1'b0, ld} - {1'b0, pop};
        e0 <= pop ? s1 : s0;
        e1 <= s1;
    end
endmodule

// File: rtl/ram_sdp_one_clock.sv
// ram_sdp_one_clock: simple dual-port RAM on one clock with a registered read port
module ram_sdp_one_clock #(
    parameter int DWIDTH = 24,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              ena,
    input  logic              enb,
    input  logic              wea,
    input  logic [AWIDTH-1:0] addra,
    input  logic [AWIDTH-1:0] addrb,
    input  logic [DWIDTH-1:0] dia,
    output logic [DWIDTH-1:0] dob
);
    logic [DWIDTH-1:0] mem [2**AWIDTH];
    always_ff @(posedge clk) begin
        if (ena && wea) mem[addra] <= dia;
        if (enb) dob <= mem[addrb];
    end
endmodule

// File: rtl/fifo_sync_fwft.sv
// fifo_sync_fwft: synchronous FWFT FIFO with programmable thresholds, fill level, flush and sticky errors
module fifo_sync_fwft #(
    parameter int DWIDTH = 24,
    parameter int DEPTH  = 256
) (
    input logic             clk,
    input logic             rst,
    fifo_sync_fwft_if.slave bus
);
    import fifo_pkg::*;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = lvl_w(DEPTH);
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [CW-1:0]     ram_cnt, level_next;
    logic [DWIDTH-1:0] dob;
    logic [1:0]        occ;
    logic              push_acc, pop_acc, issue, rd_inflight, pf_vld;
    // reads are issued only while the prefetch, counting words in flight, has room after this pop
    always_comb begin
        push_acc   = bus.push && !bus.full && !bus.flush;
        pop_acc    = bus.pop && pf_vld && !bus.flush;
        issue      = ram_cnt != '0 && {1'b0, occ} + {2'b0, rd_inflight} < {2'b0, pop_acc} + 3'd2;
        level_next = bus.level + CW'(push_acc) - CW'(pop_acc);
    end
    assign bus.vld = pf_vld;
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            bus.overflow  <= (bus.push && bus.full && !bus.flush) || (bus.overflow && !bus.err_clr);
            bus.underflow <= (bus.pop && !pf_vld && !bus.flush) || (bus.underflow && !bus.err_clr);
        end
    end
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_addr     <= '0;
            rd_addr     <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            bus.level   <= '0;
            bus.full    <= 1'b0;
            bus.alFull  <= 1'b0;
            bus.alEmpty <= 1'b1;
        end else begin
            wr_addr     <= wr_addr + AW'(push_acc);
            rd_addr     <= rd_addr + AW'(issue);
            ram_cnt     <= ram_cnt + CW'(push_acc) - CW'(issue);
            rd_inflight <= issue;
            bus.level   <= level_next;
            bus.full    <= level_next == CW'(DEPTH);
            bus.alFull  <= level_next >= bus.afull_thresh;
            bus.alEmpty <= level_next <= bus.aempty_thresh;
        end
    end
    ram_sdp_one_clock #(.DWIDTH(DWIDTH), .AWIDTH(AW)) u_ram (
        .clk   (clk),
        .ena   (push_acc),
        .enb   (issue),
        .wea   (1'b1),
        .addra (wr_addr),
        .addrb (rd_addr),
        .dia   (bus.data_in),
        .dob   (dob)
    );
    fifo_prefetch2 #(.DWIDTH(DWIDTH)) u_prefetch (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .ld       (rd_inflight),
        .din      (dob),
        .pop      (pop_acc),
        .vld      (pf_vld),
        .data_out (bus.data_out),
        .occ      (occ)
    );
endmodule

// File: tb/tb_fifo_sync_fwft.sv
// tb_fifo_sync_fwft: directed and randomized checks of fifo_sync_fwft against a timestamped queue model
module tb_fifo_sync_fwft;
    localparam int DW  = 24;
    localparam int DP  = 256;
    localparam int CWB = $clog2(DP) + 1;
    typedef struct {logic [DW-1:0] d; int t;} ent_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    ent_t mq[$];
    int cyc = 0;
    logic m_ovf = 1'b0, m_unf = 1'b0, fresh = 1'b1;
    logic [CWB-1:0] af_prev = '0, ae_prev = '0;

    fifo_sync_fwft_if #(.DWIDTH(DW), .DEPTH(DP)) bus ();
    fifo_sync_fwft #(.DWIDTH(DW), .DEPTH(DP)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // a word pushed in cycle t is the visible head no earlier than cycle t+2
    function automatic logic m_vld();
        return mq.size() != 0 && mq[0].t + 2 <= cyc;
    endfunction
    function automatic logic m_full();
        return mq.size() == DP;
    endfunction
    function automatic logic [CWB-1:0] m_level();
        return CWB'(mq.size());
    endfunction
    function automatic logic m_alf();
        return !fresh && mq.size() >= int'(af_prev);
    endfunction
    function automatic logic m_ale();
        return fresh || mq.size() <= int'(ae_prev);
    endfunction
    function automatic logic [DW-1:0] m_head();
        return m_vld() ? mq[0].d : '0;
    endfunction

    task automatic tick(input logic p, input logic [DW-1:0] d, input logic o,
                        input logic f, input logic r, input logic ec);
        logic v, fl;
        bus.push = p;
        bus.data_in = d;
        bus.pop = o;
        bus.flush = f;
        bus.err_clr = ec;
        rst = r;
        v = m_vld();
        fl = m_full();
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            fresh = 1'b1;
        end else begin
            m_ovf = (p && fl && !f) || (m_ovf && !ec);
            m_unf = (o && !v && !f) || (m_unf && !ec);
            if (f) begin
                mq.delete();
                fresh = 1'b1;
            end else begin
                if (o && v) void'(mq.pop_front());
                if (p && !fl) mq.push_back('{d, cyc});
                fresh = 1'b0;
            end
        end
        af_prev = bus.afull_thresh;
        ae_prev = bus.aempty_thresh;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        bus.afull_thresh = CWB'(250);
        bus.aempty_thresh = CWB'(2);
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 0);
        checks++;
        if ({bus.full, bus.alFull, bus.alEmpty, bus.vld, bus.overflow, bus.underflow} !== 6'b001000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=001000",
                     {bus.full, bus.alFull, bus.alEmpty, bus.vld, bus.overflow, bus.underflow});
        end
        checks++;
        if (bus.level !== '0) begin
            failures++;
            $display("FAIL reset_level got=%0d exp=0", bus.level);
        end
        checks++;
        if (bus.data_out !== '0) begin
            failures++;
            $display("FAIL reset_data got=%0h exp=0", bus.data_out);
        end
    endtask

    task automatic test_first_word();
        tick(1, 24'hA5A5A5, 0, 0, 0, 0);
        checks++;
        if (bus.level !== CWB'(1) || bus.vld !== 1'b0 || bus.alEmpty !== 1'b1) begin
            failures++;
            $display("FAIL first_t1 got=lvl%0d vld%b ae%b exp=lvl1 vld0 ae1", bus.level, bus.vld, bus.alEmpty);
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.vld !== 1'b1 || bus.data_out !== 24'hA5A5A5) begin
            failures++;
            $display("FAIL first_t2 got=vld%b %0h exp=vld1 a5a5a5", bus.vld, bus.data_out);
        end
        tick(0, 0, 1, 0, 0, 0);
        checks++;
        if (bus.level !== '0 || bus.vld !== 1'b0) begin
            failures++;
            $display("FAIL first_pop got=lvl%0d vld%b exp=lvl0 vld0", bus.level, bus.vld);
        end
    endtask

    task automatic test_simultaneous();
        tick(1, 24'h111, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 24'h222, 1, 0, 0, 0);
        checks++;
        if (bus.level !== CWB'(1) || bus.vld !== 1'b0) begin
            failures++;
            $display("FAIL sim_pushpop got=lvl%0d vld%b exp=lvl1 vld0", bus.level, bus.vld);
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.vld !== 1'b1 || bus.data_out !== 24'h222) begin
            failures++;
            $display("FAIL sim_head got=vld%b %0h exp=vld1 222", bus.vld, bus.data_out);
        end
        tick(0, 0, 1, 0, 0, 0);
        tick(1, 24'h333, 1, 0, 0, 0);
        checks++;
        if (bus.level !== CWB'(1) || bus.underflow !== 1'b1) begin
            failures++;
            $display("FAIL sim_empty got=lvl%0d unf%b exp=lvl1 unf1", bus.level, bus.underflow);
        end
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (bus.underflow !== 1'b0 || bus.vld !== 1'b1 || bus.data_out !== 24'h333) begin
            failures++;
            $display("FAIL sim_clr got=unf%b vld%b %0h exp=unf0 vld1 333", bus.underflow, bus.vld, bus.data_out);
        end
        tick(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_fill();
        for (int i = 0; i < DP; i++) begin
            tick(1, DW'(i), 0, 0, 0, 0);
            checks++;
            if (bus.level !== CWB'(i + 1) || bus.full !== (i == DP - 1) || bus.alFull !== (i + 1 >= 250)) begin
                failures++;
                $display("FAIL fill_%0d got=lvl%0d f%b af%b exp=lvl%0d f%b af%b", i, bus.level, bus.full,
                         bus.alFull, i + 1, i == DP - 1, i + 1 >= 250);
            end
        end
        tick(1, 24'h999, 0, 0, 0, 0);
        checks++;
        if (bus.overflow !== 1'b1 || bus.level !== CWB'(DP) || bus.full !== 1'b1) begin
            failures++;
            $display("FAIL fill_ovf got=ovf%b lvl%0d f%b exp=ovf1 lvl256 f1", bus.overflow, bus.level, bus.full);
        end
        checks++;
        if (bus.vld !== 1'b1 || bus.data_out !== '0) begin
            failures++;
            $display("FAIL fill_head got=vld%b %0h exp=vld1 0", bus.vld, bus.data_out);
        end
    endtask

    task automatic test_back_to_back();
        int pcount = DP;
        int popped = 0;
        logic acc;
        for (int k = 0; k < 600; k++) begin
            acc = !m_full();
            tick(1, DW'(pcount), 1, 0, 0, 0);
            if (acc) pcount++;
            popped++;
            checks++;
            if (bus.vld !== 1'b1 || bus.data_out !== DW'(popped) || bus.level !== CWB'(DP - 1)) begin
                failures++;
                $display("FAIL stream_%0d got=vld%b %0h lvl%0d exp=vld1 %0h lvl255", k, bus.vld,
                         bus.data_out, bus.level, popped);
            end
        end
    endtask

    task automatic test_thresholds();
        int lvl;
        bus.aempty_thresh = CWB'(3);
        for (int k = 0; k < 252; k++) begin
            tick(0, 0, 1, 0, 0, 0);
            lvl = DP - 2 - k;
            checks++;
            if (bus.level !== CWB'(lvl) || bus.alEmpty !== (lvl <= 3) || bus.alFull !== (lvl >= 250)) begin
                failures++;
                $display("FAIL thr_%0d got=lvl%0d ae%b af%b exp=lvl%0d ae%b af%b", k, bus.level,
                         bus.alEmpty, bus.alFull, lvl, lvl <= 3, lvl >= 250);
            end
        end
    endtask

    task automatic test_underflow();
        for (int k = 0; k < 3; k++) tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (bus.level !== '0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            failures++;
            $display("FAIL unf_clear got=lvl%0d ovf%b unf%b exp=lvl0 ovf0 unf0", bus.level, bus.overflow, bus.underflow);
        end
        tick(0, 0, 1, 0, 0, 0);
        checks++;
        if (bus.underflow !== 1'b1 || bus.level !== '0) begin
            failures++;
            $display("FAIL unf_set got=unf%b lvl%0d exp=unf1 lvl0", bus.underflow, bus.level);
        end
        tick(0, 0, 1, 0, 0, 1);
        checks++;
        if (bus.underflow !== 1'b1) begin
            failures++;
            $display("FAIL unf_setwins got=%b exp=1", bus.underflow);
        end
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if (bus.underflow !== 1'b0) begin
            failures++;
            $display("FAIL unf_clr got=%b exp=0", bus.underflow);
        end
    endtask

    task automatic test_flush();
        tick(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(1, DW'(100 + i), 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 24'hBAD, 1, 1, 0, 0);
        checks++;
        if ({bus.vld, bus.full, bus.alEmpty, bus.overflow, bus.underflow} !== 5'b00101 || bus.level !== '0) begin
            failures++;
            $display("FAIL flush_state got=%b lvl%0d exp=00101 lvl0",
                     {bus.vld, bus.full, bus.alEmpty, bus.overflow, bus.underflow}, bus.level);
        end
        tick(1, 24'h123456, 0, 0, 0, 0);
        checks++;
        if (bus.vld !== 1'b0 || bus.level !== CWB'(1)) begin
            failures++;
            $display("FAIL flush_t1 got=vld%b lvl%0d exp=vld0 lvl1", bus.vld, bus.level);
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.vld !== 1'b1 || bus.data_out !== 24'h123456) begin
            failures++;
            $display("FAIL flush_head got=vld%b %0h exp=vld1 123456", bus.vld, bus.data_out);
        end
        for (int i = 0; i < 10; i++) tick(1, DW'(200 + i), 0, 0, 0, 0);
        tick(1, 24'hBAD, 1, 1, 1, 0);
        checks++;
        if ({bus.full, bus.alFull, bus.alEmpty, bus.vld, bus.overflow, bus.underflow} !== 6'b001000
            || bus.level !== '0 || bus.data_out !== '0) begin
            failures++;
            $display("FAIL rst_mid got=%b lvl%0d %0h exp=001000 lvl0 0",
                     {bus.full, bus.alFull, bus.alEmpty, bus.vld, bus.overflow, bus.underflow},
                     bus.level, bus.data_out);
        end
        tick(1, 24'h654321, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.vld !== 1'b1 || bus.data_out !== 24'h654321) begin
            failures++;
            $display("FAIL rst_head got=vld%b %0h exp=vld1 654321", bus.vld, bus.data_out);
        end
    endtask

    task automatic test_random();
        int pp, op;
        for (int ph = 0; ph < 4; ph++) begin
            pp = ph == 0 ? 90 : ph == 1 ? 25 : 60;
            op = ph == 0 ? 25 : ph == 1 ? 90 : 60;
            for (int k = 0; k < 800; k++) begin
                if ($urandom_range(0, 49) == 0) bus.afull_thresh = CWB'($urandom_range(0, DP + 2));
                if ($urandom_range(0, 49) == 0) bus.aempty_thresh = CWB'($urandom_range(0, DP + 2));
                tick($urandom_range(0, 99) < pp, DW'($urandom), $urandom_range(0, 99) < op,
                     ph >= 2 && $urandom_range(0, 299) == 0, ph >= 2 && $urandom_range(0, 699) == 0,
                     $urandom_range(0, 29) == 0);
                checks++;
                if (bus.level !== m_level()) begin
                    failures++;
                    $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cyc, bus.level, m_level());
                end
                checks++;
                if ({bus.full, bus.alFull, bus.alEmpty} !== {m_full(), m_alf(), m_ale()}) begin
                    failures++;
                    $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, {bus.full, bus.alFull, bus.alEmpty},
                             {m_full(), m_alf(), m_ale()});
                end
                checks++;
                if (bus.vld !== m_vld() || (m_vld() && bus.data_out !== m_head())) begin
                    failures++;
                    $display("FAIL rnd_head cyc=%0d got=vld%b %0h exp=vld%b %0h", cyc, bus.vld,
                             bus.data_out, m_vld(), m_head());
                end
                checks++;
                if ({bus.overflow, bus.underflow} !== {m_ovf, m_unf}) begin
                    failures++;
                    $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, {bus.overflow, bus.underflow}, {m_ovf, m_unf});
                end
            end
        end
    endtask

    initial begin
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.flush = 1'b0;
        bus.err_clr = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_first_word();
        test_simultaneous();
        test_fill();
        test_back_to_back();
        test_thresholds();
        test_underflow();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_sync_fwft.md
Name: fifo_sync_fwft

Overview:
- Next-generation parametrised synchronous FIFO for the classifier datapath.
- First-word-fall-through: the head word is presented on data_out with vld high, without a prior pop.
- Sustains one push and one pop per clock.
- Adds runtime-programmable almost-full/almost-empty thresholds, a fill-level output, synchronous flush, and sticky overflow/underflow error flags. Storage is the existing ram_sdp_one_clock.

Parameters:
- DWIDTH, 24, data word width in bits.
- DEPTH, 256, total capacity in words; power of 2, >= 4.
- CW, $clog2(DEPTH)+1, localparam: width of level and threshold ports.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of contents.
- push  input  1  write request.
- data_in  input  DWIDTH  write data.
- full  output  1  registered; no push accepted while high.
- alFull  output  1  registered; level >= afull_thresh.
- pop  input  1  consume head word; effective only when vld.
- vld  output  1  data_out holds a valid head word.
- data_out  output  DWIDTH  head word.
- alEmpty  output  1  registered; level <= aempty_thresh.
- level  output  CW  registered count of accepted, not-yet-popped words (0..DEPTH).
- afull_thresh  input  CW  almost-full threshold, sampled every cycle.
- aempty_thresh  input  CW  almost-empty threshold, sampled every cycle.
- err_clr  input  1  clears sticky error flags.
- overflow  output  1  sticky: push while full.
- underflow  output  1  sticky: pop while !vld.

Behaviour:
- Acceptance:
  - push_acc = push && !full.
  - pop_acc = pop && vld.
  - Rejected push: data dropped, no state change except overflow.
  - Rejected pop: ignored, no state change except underflow.
- Write path: accepted word is written to RAM in the same cycle at wr_addr; wr_addr increments and wraps mod DEPTH.
- Read path: 2-entry prefetch buffer (fifo_prefetch2) fed from RAM with 1-cycle read latency.
  - A RAM read is issued when ram_cnt > 0 and (prefetch occupancy + reads in flight - pop_acc) < 2.
  - rd_addr increments and wraps on each issue.
  - A word written at cycle t is readable from t+1.
- Latency: push into an empty FIFO at cycle t gives vld=1 with that word at t+2. Back-to-back pushes then continuous pops sustain 1 word/clk with no vld bubbles.
- Ordering: strict FIFO order; data_out stable while vld && !pop.
- Level: level_next = level + push_acc - pop_acc.
  - level counts RAM words plus prefetch and in-flight words.
  - full is set when level_next == DEPTH, so RAM never overruns.
- Status flags: level, full, alFull and alEmpty are all registered from level_next and the current thresholds, and so reflect an event one cycle after it.
  - alFull uses a threshold of 0, which keeps it permanently high.
  - alEmpty uses a threshold >= DEPTH, which keeps it permanently high.
- Simultaneous events:
  - Push and pop while full: the pop is accepted; the push is rejected (full is registered) and sets overflow.
  - Push and pop while level=1 and vld: both are accepted; level remains 1.
  - Push while empty with pop: pop ignored, underflow set, push accepted.
- Errors: overflow/underflow set the cycle after the offending request. Cleared by err_clr; if set and clear coincide, set wins. Unaffected by flush.
- Flush: the next cycle sees the same state as after reset for pointers, counters, prefetch, in-flight reads and status flags. Push/pop in the flush cycle are ignored, and flush does not set the error flags.
- Reset values: full=0, alFull=0, alEmpty=1, vld=0, data_out=0, level=0, overflow=0, underflow=0. Reset mid-operation discards all contents and in-flight reads. rst has priority over flush.
- Arithmetic: level and ram_cnt are CW bits and never wrap; pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Package fifo_pkg: no typedefs needed beyond a function for clog2-based widths; an lvl_t typedef is optional.
- Reuse ram_sdp_one_clock for storage.
- Sub-module fifo_prefetch2: the 2-entry output skid buffer.
  - Inputs: load from RAM dob with a valid tag from the issue pipeline, pop, flush/rst.
  - Outputs: vld, data_out, occupancy.
- Top-level logic: pointers, counters, flags, errors.

Test Plan:
- Reset, then push 0xA5A5A5 at t0 -> vld=1 and data_out=0xA5A5A5 at t0+2; level=1 from t0+1; alEmpty=1 (aempty_thresh=2).
- Push 256 words (values 0..255) with no pop -> full=1 the cycle after the 256th push; level=256; a 257th push sets overflow=1 and 0 remains the head.
- With DEPTH full, drive push and pop every cycle for 600 cycles with an incrementing pattern -> data_out sequence 0,1,2,... with no gaps; level stays 255/256; pointers wrap at least twice.
- With afull_thresh=250 and aempty_thresh=3, fill to 250 -> alFull rises the cycle after the 250th push; drain to 3 -> alEmpty rises the cycle after the level reaches 3.
- Pop while empty -> underflow=1 and level stays 0; err_clr coincident with another empty pop -> underflow remains 1; next err_clr alone -> 0.
- Load 10 words, then assert flush coincident with push and pop -> next cycle level=0, vld=0, full=0, alEmpty=1, errors unchanged; subsequent push 0x123456 is the head at +2 cycles. Repeat with rst instead -> all outputs at reset values.
